// File: rtl/start_sprite_fetch.sv
// start_sprite_fetch
// Feeds the start-screen colour decoder: maps VGA pixel coordinates onto an
// upscaled sprite window, addresses a synchronous 4-bit colour-index ROM and
// returns a pixel-aligned colour index. It also generates a frame-synchronous
// blink flag (is_b) that selects the decoder's alternate palette.
//
// Pipeline (advances only on pix_en):
//   stage 0 (comb)   : window test + texel address
//   stage 1 (reg)    : rom_addr, window flag, valid flag
//   stage 2 (reg)    : colour index (ROM data masked by window), in_sprite,
//                      out_valid
// Because rom_addr is held while pix_en is low, rom_data stays stable during
// a stall and stage 2 captures the right texel whenever the next tick comes.
module start_sprite_fetch #(
    parameter int unsigned SPR_X        = 192,
    parameter int unsigned SPR_Y        = 112,
    parameter int unsigned SPR_W        = 128,
    parameter int unsigned SPR_H        = 64,
    parameter int unsigned SCALE_SH     = 1,
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              vid_valid,
    input  logic              frame_start,
    input  logic              blink_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        start_color_index,
    output logic              is_b,
    output logic              out_valid,
    output logic              in_sprite
);

    // Window bounds are compared at 11 bits so that the exclusive upper edge
    // cannot wrap even when the window touches the end of the 10-bit range.
    localparam logic [10:0] X_LO = 11'(SPR_X);
    localparam logic [10:0] X_HI = 11'(SPR_X + (SPR_W << SCALE_SH));
    localparam logic [10:0] Y_LO = 11'(SPR_Y);
    localparam logic [10:0] Y_HI = 11'(SPR_Y + (SPR_H << SCALE_SH));

    // Offsets for the texel subtraction, at the coordinate width.
    localparam logic [9:0] X_OFF = 10'(SPR_X);
    localparam logic [9:0] Y_OFF = 10'(SPR_Y);

    // Row stride at address width; the product is naturally truncated to
    // ADDR_W, which is the intended address wrap.
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SPR_W);

    // Terminal value of the frame counter before is_b toggles.
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Stage 0 signals
    // ------------------------------------------------------------------
    logic              win_s;
    logic [9:0]        dx_s;
    logic [9:0]        dy_s;
    logic [9:0]        tx_s;
    logic [9:0]        ty_s;
    logic [ADDR_W-1:0] addr_s;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rom_addr_q,  rom_addr_d;
    logic              s1_win_q,    s1_win_d;
    logic              s1_vld_q,    s1_vld_d;
    logic [3:0]        idx_q,       idx_d;
    logic              in_sprite_q, in_sprite_d;
    logic              out_valid_q, out_valid_d;

    // ------------------------------------------------------------------
    // Blink state
    // ------------------------------------------------------------------
    logic [7:0] fcnt_q, fcnt_d;
    logic       is_b_q, is_b_d;

    // Window test and texel address; subtractions only happen inside the
    // window so an out-of-window coordinate can never produce a wrapped address.
    always_comb begin
        win_s = vid_valid
             && ({1'b0, h_cnt} >= X_LO) && ({1'b0, h_cnt} < X_HI)
             && ({1'b0, v_cnt} >= Y_LO) && ({1'b0, v_cnt} < Y_HI);
        dx_s   = 10'd0;
        dy_s   = 10'd0;
        tx_s   = 10'd0;
        ty_s   = 10'd0;
        addr_s = '0;
        if (win_s) begin
            dx_s   = h_cnt - X_OFF;
            dy_s   = v_cnt - Y_OFF;
            tx_s   = dx_s >> SCALE_SH;
            ty_s   = dy_s >> SCALE_SH;
            addr_s = (ADDR_W'(ty_s) * ROW_STRIDE) + ADDR_W'(tx_s);
        end else begin
            addr_s = '0;
        end
    end

    // Next-state for both pipeline stages: advance on pix_en, hold otherwise.
    always_comb begin
        rom_addr_d  = rom_addr_q;
        s1_win_d    = s1_win_q;
        s1_vld_d    = s1_vld_q;
        idx_d       = idx_q;
        in_sprite_d = in_sprite_q;
        out_valid_d = out_valid_q;
        if (pix_en) begin
            rom_addr_d  = addr_s;
            s1_win_d    = win_s;
            s1_vld_d    = vid_valid;
            idx_d       = s1_win_q ? rom_data : 4'd0;
            in_sprite_d = s1_win_q;
            out_valid_d = s1_vld_q;
        end else begin
            rom_addr_d  = rom_addr_q;
            idx_d       = idx_q;
        end
    end

    // Next-state for the blink counter; it only moves on frame_start so is_b
    // can never change in the middle of a frame. A low blink_en clears, and
    // that clear takes priority over a toggle on the same frame_start.
    always_comb begin
        fcnt_d = fcnt_q;
        is_b_d = is_b_q;
        if (frame_start) begin
            if (!blink_en) begin
                fcnt_d = 8'd0;
                is_b_d = 1'b0;
            end else if (fcnt_q == BLINK_LAST) begin
                fcnt_d = 8'd0;
                is_b_d = ~is_b_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
                is_b_d = is_b_q;
            end
        end else begin
            fcnt_d = fcnt_q;
            is_b_d = is_b_q;
        end
    end

    // Pipeline registers with synchronous active-low reset (flushes mid-frame).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr_q  <= '0;
            s1_win_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            idx_q       <= 4'd0;
            in_sprite_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            s1_win_q    <= s1_win_d;
            s1_vld_q    <= s1_vld_d;
            idx_q       <= idx_d;
            in_sprite_q <= in_sprite_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Blink state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt_q <= 8'd0;
            is_b_q <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            is_b_q <= is_b_d;
        end
    end

    assign rom_addr          = rom_addr_q;
    assign start_color_index = idx_q;
    assign in_sprite         = in_sprite_q;
    assign out_valid         = out_valid_q;
    assign is_b              = is_b_q;

endmodule

// File: tb/tb_start_sprite_fetch.sv
// Directed, table-driven bench for start_sprite_fetch. The ROM is modelled
// as data = rom_addr[3:0] (or a forced 4'h7); expected values are hand-computed.
module tb_start_sprite_fetch;

    logic        clk;
    logic        rst_n;
    logic        pix_en;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        vid_valid;
    logic        frame_start;
    logic        blink_en;
    logic [12:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  start_color_index;
    logic        is_b;
    logic        out_valid;
    logic        in_sprite;
    logic        rom_force;

    int checks;
    int errors;

    start_sprite_fetch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pix_en            (pix_en),
        .h_cnt             (h_cnt),
        .v_cnt             (v_cnt),
        .vid_valid         (vid_valid),
        .frame_start       (frame_start),
        .blink_en          (blink_en),
        .rom_addr          (rom_addr),
        .rom_data          (rom_data),
        .start_color_index (start_color_index),
        .is_b              (is_b),
        .out_valid         (out_valid),
        .in_sprite         (in_sprite)
    );

    assign rom_data = rom_force ? 4'h7 : rom_addr[3:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        vv;
        logic [12:0] exp_addr;
        logic        exp_win;
        logic [3:0]  exp_idx;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic vv);
        h_cnt     = h;
        v_cnt     = v;
        vid_valid = vv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rom_force   = 1'b0;
        frame_start = 1'b0;
        blink_en    = 1'b0;
        pix_en      = 1'b1;
        rst_n       = 1'b0;
        drive(10'd0, 10'd0, 1'b0);

        //            h        v       vv    addr        win   idx
        vecs[0]  = '{10'd192, 10'd112, 1'b1, 13'd0,    1'b1, 4'h0};
        vecs[1]  = '{10'd195, 10'd114, 1'b1, 13'd129,  1'b1, 4'h1};
        vecs[2]  = '{10'd447, 10'd239, 1'b1, 13'd8191, 1'b1, 4'hF};
        vecs[3]  = '{10'd191, 10'd112, 1'b1, 13'd0,    1'b0, 4'h0};
        vecs[4]  = '{10'd448, 10'd112, 1'b1, 13'd0,    1'b0, 4'h0};
        vecs[5]  = '{10'd192, 10'd240, 1'b1, 13'd0,    1'b0, 4'h0};
        vecs[6]  = '{10'd300, 10'd150, 1'b0, 13'd0,    1'b0, 4'h0};
        vecs[7]  = '{10'd200, 10'd120, 1'b1, 13'd516,  1'b1, 4'h4};
        vecs[8]  = '{10'd447, 10'd112, 1'b1, 13'd127,  1'b1, 4'hF};
        vecs[9]  = '{10'd194, 10'd239, 1'b1, 13'd8065, 1'b1, 4'h1};
        vecs[10] = '{10'd192, 10'd111, 1'b1, 13'd0,    1'b0, 4'h0};

        // ---------------- reset ----------------
        for (int i = 0; i < 3; i++) begin
            drive(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 1'b1);
            tick();
        end
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_index", 32'(start_color_index), 32'd0);
        chk("rst_is_b", 32'(is_b), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_sprite", 32'(in_sprite), 32'd0);

        // release: out_valid rises exactly 2 pix_en ticks after first valid sample
        rst_n = 1'b1;
        drive(10'd200, 10'd120, 1'b1);
        tick();
        chk("rel_valid_t1", 32'(out_valid), 32'd0);
        tick();
        chk("rel_valid_t2", 32'(out_valid), 32'd1);
        chk("rel_index_t2", 32'(start_color_index), 32'd4);

        // ---------------- window mapping table, pix_en every clk ----------------
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) drive(vecs[i].h, vecs[i].v, vecs[i].vv);
            else        drive(10'd0, 10'd0, 1'b0);
            tick();
            if (i < NV) chk($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
            if (i >= 1) begin
                chk($sformatf("vec%0d_index", i - 1), 32'(start_color_index), 32'(vecs[i-1].exp_idx));
                chk($sformatf("vec%0d_in_sprite", i - 1), 32'(in_sprite), 32'(vecs[i-1].exp_win));
                chk($sformatf("vec%0d_out_valid", i - 1), 32'(out_valid), 32'(vecs[i-1].vv));
            end
        end

        // ---------------- out of window ignores rom_data ----------------
        rom_force = 1'b1;
        drive(10'd191, 10'd112, 1'b1);
        tick();
        drive(10'd0, 10'd0, 1'b0);
        tick();
        chk("oow_force_index", 32'(start_color_index), 32'd0);
        chk("oow_force_in_sprite", 32'(in_sprite), 32'd0);
        chk("oow_force_valid", 32'(out_valid), 32'd1);
        tick();

        // ---------------- stall: pix_en every 4 clks ----------------
        pix_en = 1'b0;
        drive(10'd200, 10'd120, 1'b1);
        pix_en = 1'b1;
        tick();                       // pulse 1 captures window pixel
        pix_en = 1'b0;
        drive(10'd0, 10'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall1_rom_addr_%0d", k), 32'(rom_addr), 32'd516);
            chk($sformatf("stall1_index_%0d", k), 32'(start_color_index), 32'd0);
            chk($sformatf("stall1_valid_%0d", k), 32'(out_valid), 32'd0);
        end
        pix_en = 1'b1;
        tick();                       // pulse 2 presents the window pixel
        pix_en = 1'b0;
        chk("stall2_index", 32'(start_color_index), 32'd7);
        chk("stall2_in_sprite", 32'(in_sprite), 32'd1);
        chk("stall2_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall2_hold_index_%0d", k), 32'(start_color_index), 32'd7);
            chk($sformatf("stall2_hold_valid_%0d", k), 32'(out_valid), 32'd1);
        end
        pix_en = 1'b1;
        tick();                       // pulse 3 presents the invalid pixel
        chk("stall3_valid", 32'(out_valid), 32'd0);
        chk("stall3_index", 32'(start_color_index), 32'd0);
        rom_force = 1'b0;

        // ---------------- blink: 70 frames ----------------
        blink_en = 1'b1;
        for (int p = 1; p <= 70; p++) begin
            fs_pulse();
            chk($sformatf("blink_p%0d", p), 32'(is_b), 32'((p / 30) % 2));
        end

        // ---------------- blink drop at pulse 45 ----------------
        blink_en = 1'b0;
        fs_pulse();                   // clear: is_b=0, fcnt=0
        chk("drop_clear", 32'(is_b), 32'd0);
        blink_en = 1'b1;
        for (int p = 1; p <= 44; p++) fs_pulse();
        chk("drop_p44", 32'(is_b), 32'd1);
        blink_en = 1'b0;
        tick();
        tick();
        chk("drop_no_midframe", 32'(is_b), 32'd1);
        fs_pulse();                   // pulse 45
        chk("drop_p45", 32'(is_b), 32'd0);
        blink_en = 1'b1;
        for (int p = 1; p <= 29; p++) fs_pulse();
        chk("restart_p29", 32'(is_b), 32'd0);
        fs_pulse();
        chk("restart_p30", 32'(is_b), 32'd1);

        // ---------------- clear at terminal count ----------------
        blink_en = 1'b0;
        fs_pulse();
        blink_en = 1'b1;
        for (int p = 1; p <= 29; p++) fs_pulse();     // fcnt now at terminal
        chk("term_before", 32'(is_b), 32'd0);
        blink_en = 1'b0;
        fs_pulse();
        chk("term_clear_no_toggle", 32'(is_b), 32'd0);
        blink_en = 1'b1;
        for (int p = 1; p <= 29; p++) fs_pulse();
        chk("term_fcnt_zero_p29", 32'(is_b), 32'd0);
        fs_pulse();
        chk("term_fcnt_zero_p30", 32'(is_b), 32'd1);

        // ---------------- reset mid-frame flushes pipeline ----------------
        pix_en = 1'b1;
        drive(10'd200, 10'd120, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_is_b", 32'(is_b), 32'd0);
        chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_rel_t1", 32'(out_valid), 32'd0);
        tick();
        chk("midrst_rel_t2", 32'(out_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/start_sprite_fetch.md
Name: start_sprite_fetch

Overview:
Upstream feeder for the start-screen colour decoder. It maps VGA pixel coordinates onto a scaled start-screen sprite window and issues addresses to a synchronous 4-bit colour-index ROM. It returns the pixel-aligned colour index plus a frame-synchronous blink flag, is_b, that drives the decoder's alternate-palette input. Outputs are pipelined, so index, valid and window flags stay aligned with each other.

Parameters:
SPR_X, 192, left edge of displayed sprite window (screen px)
SPR_Y, 112, top edge of displayed sprite window (screen px)
SPR_W, 128, sprite width in ROM texels
SPR_H, 64, sprite height in ROM texels
SCALE_SH, 1, upscale shift; each texel covers (1<<SCALE_SH)² screen px
ADDR_W, 13, ROM address width; must satisfy 2^ADDR_W ≥ SPR_W*SPR_H
BLINK_FRAMES, 30, frames per is_b half-period; legal range 1..255

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pix_en  in  1  pixel tick; pipeline advances only when high
h_cnt  in  10  current pixel column
v_cnt  in  10  current pixel row
vid_valid  in  1  h_cnt/v_cnt inside visible area
frame_start  in  1  one-clk pulse at the first pixel of each frame
blink_en  in  1  enables is_b toggling
rom_addr  out  ADDR_W  address to sync ROM; ROM data valid 1 clk later
rom_data  in  4  colour index from ROM
start_color_index  out  4  index to decoder; 0 = transparent
is_b  out  1  alternate-palette select
out_valid  out  1  start_color_index corresponds to a visible pixel
in_sprite  out  1  pixel lies inside the sprite window

Behaviour:
- Reset: all outputs 0, including rom_addr, start_color_index, is_b, out_valid and in_sprite. Frame counter is 0. Both pipeline stages are cleared.
- Window test (stage 0, combinational): win = vid_valid && h_cnt ≥ SPR_X && h_cnt < SPR_X+(SPR_W<<SCALE_SH) && v_cnt ≥ SPR_Y && v_cnt < SPR_Y+(SPR_H<<SCALE_SH).
- Address: tx = (h_cnt−SPR_X)>>SCALE_SH and ty = (v_cnt−SPR_Y)>>SCALE_SH, computed at 10-bit width. addr = ty*SPR_W + tx, truncated to ADDR_W. When win=0, addr = 0. Subtractions are used only when win=1, so no underflow can reach the ROM.
- Stage 1, on clk with pix_en=1: rom_addr←addr, s1_win←win, s1_vld←vid_valid.
- Stage 2, on clk with pix_en=1: start_color_index ← s1_win ? rom_data : 0, in_sprite←s1_win, out_valid←s1_vld.
- pix_en=0: every stage holds. rom_addr is held, so rom_data stays stable across the stall.
- Latency: outputs reflect coordinates sampled 2 pix_en ticks earlier. This holds for pix_en high every clk and for pix_en sparse (≥1 clk gap).
- Blink counter, 8-bit fcnt, advances on frame_start only:
  - blink_en=0: fcnt←0, is_b←0.
  - blink_en=1: if fcnt = BLINK_FRAMES−1, then fcnt←0 and is_b←~is_b; otherwise fcnt←fcnt+1.
  - is_b never changes mid-frame.
  - frame_start is independent of pix_en.
- Simultaneous frame_start and blink_en falling: the clear wins.
- Reset mid-frame: the pipeline flushes to 0. The first valid output appears 2 pix_en ticks after rst_n rises.

Test Plan:
- Reset: hold rst_n=0 for 3 clks with pix_en=1 and random coords → all outputs 0. Release → out_valid first rises 2 pix_en ticks after the first vid_valid=1 sample.
- Window mapping, pix_en every clk, ROM model data = addr[3:0]:
  - (h,v)=(192,112) → rom_addr=0, index=0 two clks later, in_sprite=1.
  - (195,114) → rom_addr=1*128+1=129, index=1.
  - (447,239) → rom_addr=8191.
- Out of window: (191,112), (448,112), (192,240) and vid_valid=0 → rom_addr=0, in_sprite=0, index=0 irrespective of rom_data.
- Stall: pix_en pulses every 4 clks with rom_data forced to 4'h7 inside the window → index=7 appears exactly 2 pulses later and holds between pulses.
- Blink: blink_en=1, 70 frame_start pulses → is_b toggles at pulses 30 and 60 (0→1→0). Drop blink_en at pulse 45 → is_b=0 immediately; fcnt restarts from 0.
- Simultaneous frame_start with blink_en low at counter terminal count → no toggle, is_b=0, fcnt=0.
